// File: rtl/rr_priority_encoder_pkg.sv
// -----------------------------------------------------------------------------
// rr_priority_encoder_pkg
// Shared constants for the round-robin priority encoder and the datapath
// select-line decoders. Both sides agree on the select width through these
// defaults.
//   IDX_WIDTH_DEF : default width of the encoded select index
//   N_REQ_DEF     : default number of request lines
//   state_t       : encoder FSM state encoding (ST_IDLE / ST_HOLD)
// -----------------------------------------------------------------------------
package rr_priority_encoder_pkg;

  localparam int IDX_WIDTH_DEF = 6;
  localparam int N_REQ_DEF     = 36;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage : rr_priority_encoder_pkg

// File: rtl/rr_scan.sv
// -----------------------------------------------------------------------------
// rr_scan
// Purely combinational round-robin search. The request vector is rotated so
// that line ptr lands at position 0, the lowest set bit of the rotated vector
// is found, and its offset is rotated back into an absolute line number.
// Ports:
//   req        in  N_REQ      request vector (multi-hot)
//   ptr        in  IDX_WIDTH  highest-priority line, always < N_REQ
//   found      out 1          at least one request line is set
//   sel_idx    out IDX_WIDTH  selected line (0 when nothing is found)
//   sel_onehot out N_REQ      one-hot of sel_idx (all-zero when nothing found)
// -----------------------------------------------------------------------------
module rr_scan
  import rr_priority_encoder_pkg::*;
#(
  parameter int IDX_WIDTH = IDX_WIDTH_DEF,
  parameter int N_REQ     = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]     req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] sel_idx,
  output logic [N_REQ-1:0]     sel_onehot
);

  logic [N_REQ-1:0]     rot;
  logic [IDX_WIDTH-1:0] off;

  // Modulo-N_REQ addition; both operands are already below N_REQ, so a single
  // conditional subtraction is enough.
  function automatic logic [IDX_WIDTH-1:0] wrap_add(
    input logic [IDX_WIDTH-1:0] a,
    input logic [IDX_WIDTH-1:0] b
  );
    logic [IDX_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_WIDTH+1)'(N_REQ)) begin
      s = s - (IDX_WIDTH+1)'(N_REQ);
    end else begin
      s = s;
    end
    return s[IDX_WIDTH-1:0];
  endfunction

  // Rotate the request vector so that line ptr sits at bit 0.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rot[k] = req[wrap_add(ptr, IDX_WIDTH'(k))];
    end
  end

  // Find-first-set on the rotated vector; the descending loop lets the lowest
  // set bit win.
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IDX_WIDTH'(k);
      end else begin
        off = off;
      end
    end
  end

  assign found = |req;

  // Rotate the offset back into an absolute line number and build its one-hot.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    if (found) begin
      sel_idx             = wrap_add(ptr, off);
      sel_onehot[sel_idx] = 1'b1;
    end else begin
      sel_idx    = '0;
      sel_onehot = '0;
    end
  end

endmodule : rr_scan

// File: rtl/rr_priority_encoder.sv
// -----------------------------------------------------------------------------
// rr_priority_encoder
// Sequential round-robin priority encoder: turns a multi-hot request vector
// into a registered binary select index plus matching one-hot grant. Input and
// output use valid/ready handshakes; a produced index is held until acked.
// Ports:
//   clk        in  1          rising-edge clock
//   reset      in  1          synchronous active-high reset
//   req        in  N_REQ      request vector (multi-hot)
//   req_valid  in  1          req is presented
//   req_ready  out 1          req is accepted this cycle
//   idx        out IDX_WIDTH  granted line
//   grant      out N_REQ      one-hot of idx
//   out_valid  out 1          idx/grant valid
//   out_ready  in  1          consumer acknowledges idx
//   zero_err   out 1          (only with RR_ENC_ZERO_ERR_EN) one-cycle pulse
//                             after an all-zero request is accepted
// Build option: define RR_ENC_ZERO_ERR_EN to add the zero_err port. Without it
// all-zero requests are dropped silently.
// -----------------------------------------------------------------------------
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter int IDX_WIDTH = IDX_WIDTH_DEF,
  parameter int N_REQ     = N_REQ_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [IDX_WIDTH-1:0] idx,
  output logic [N_REQ-1:0]     grant,
  output logic                 out_valid,
`ifdef RR_ENC_ZERO_ERR_EN
  output logic                 zero_err,
`endif
  input  logic                 out_ready
);

  state_t               state_r,  state_next;
  logic [IDX_WIDTH-1:0] ptr_r,    ptr_next;
  logic [IDX_WIDTH-1:0] idx_r,    idx_next;
  logic [N_REQ-1:0]     grant_r,  grant_next;
`ifdef RR_ENC_ZERO_ERR_EN
  logic                 zero_err_r, zero_err_next;
`endif

  logic                 consume;
  logic                 accept;
  logic [IDX_WIDTH-1:0] ptr_after;
  logic [IDX_WIDTH-1:0] ptr_eff;
  logic                 found;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [N_REQ-1:0]     sel_onehot;

  // Ready is combinational on out_ready so a held result and a new request can
  // be exchanged in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_HOLD: req_ready = out_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign consume   = (state_r == ST_HOLD) && out_ready;
  assign accept    = req_valid && req_ready;
  assign ptr_after = (idx_r == IDX_WIDTH'(N_REQ - 1)) ? '0 : idx_r + IDX_WIDTH'(1);
  // A request accepted while the previous result is consumed must already see
  // the advanced pointer, otherwise back-to-back grants would repeat a line.
  assign ptr_eff   = consume ? ptr_after : ptr_r;

  rr_scan #(
    .IDX_WIDTH (IDX_WIDTH),
    .N_REQ     (N_REQ)
  ) u_scan (
    .req        (req),
    .ptr        (ptr_eff),
    .found      (found),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot)
  );

  // Next-state, pointer and output-register update logic.
  always_comb begin
    state_next = state_r;
    ptr_next   = ptr_r;
    idx_next   = idx_r;
    grant_next = grant_r;
`ifdef RR_ENC_ZERO_ERR_EN
    zero_err_next = 1'b0;
`endif
    if (consume) begin
      ptr_next   = ptr_after;
      state_next = ST_IDLE;
    end else begin
      ptr_next = ptr_r;
    end
    if (accept) begin
      if (found) begin
        idx_next   = sel_idx;
        grant_next = sel_onehot;
        state_next = ST_HOLD;
      end else begin
        // All-zero request: consumed, nothing produced, pointer untouched.
        state_next = ST_IDLE;
`ifdef RR_ENC_ZERO_ERR_EN
        zero_err_next = 1'b1;
`endif
      end
    end else begin
      idx_next = idx_r;
    end
  end

  // State, pointer and output registers; reset overrides any pending event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      idx_r   <= '0;
      grant_r <= '0;
`ifdef RR_ENC_ZERO_ERR_EN
      zero_err_r <= 1'b0;
`endif
    end else begin
      state_r <= state_next;
      ptr_r   <= ptr_next;
      idx_r   <= idx_next;
      grant_r <= grant_next;
`ifdef RR_ENC_ZERO_ERR_EN
      zero_err_r <= zero_err_next;
`endif
    end
  end

  assign idx       = idx_r;
  assign grant     = grant_r;
  assign out_valid = (state_r == ST_HOLD);
`ifdef RR_ENC_ZERO_ERR_EN
  assign zero_err  = zero_err_r;
`endif

endmodule : rr_priority_encoder
